// File: rtl/sum4_display_scan_if.sv
// sum4_display_scan_if: adder-result capture inputs and 7-segment display outputs.
interface sum4_display_scan_if;
    logic [3:0] sum_i;
    logic       cout_i;
    logic       load_i;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       disp_valid_o;
    modport master (output sum_i, cout_i, load_i, input seg_o, an_o, disp_valid_o);
    modport slave  (input sum_i, cout_i, load_i, output seg_o, an_o, disp_valid_o);
endinterface

// File: rtl/sum4_display_scan.sv
// sum4_display_scan: captures the 5-bit adder result and scans it as decimal on a 4-digit display.
// Define SUM4_DISP_HEX_EN to show the hex value on digits 2 and 3.
module sum4_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic clk,
    input logic rst_n,
    sum4_display_scan_if.slave bus
);
    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_e;
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
`ifdef SUM4_DISP_HEX_EN
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
`endif
            default: glyph = 7'h7F;
        endcase
    endfunction

    state_e state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0] tens_q, tens_d, tens_n;
    logic [3:0] units_q, units_d, units_n, dig;
    logic valid_q, valid_d, wrap, blank;
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic [4:0] v;
`ifdef SUM4_DISP_HEX_EN
    logic [4:0] value_q, value_d;
`endif

    always_comb begin
        v = {bus.cout_i, bus.sum_i};
        tens_n = v >= 5'd30 ? 2'd3 : v >= 5'd20 ? 2'd2 : v >= 5'd10 ? 2'd1 : 2'd0;
        // v - 10*tens, with 10*tens built as 8*tens + 2*tens
        units_n = 4'(v - {tens_n, 3'b000} - {2'b00, tens_n, 1'b0});
        tens_d = bus.load_i ? tens_n : tens_q;
        units_d = bus.load_i ? units_n : units_q;
        valid_d = valid_q | bus.load_i;
        wrap = presc_q == LAST;
        presc_d = wrap ? '0 : presc_q + PW'(1);
        state_d = !wrap ? state_q : state_q == DIG0 ? DIG1 : state_q == DIG1 ? DIG2 :
                  state_q == DIG2 ? DIG3 : DIG0;
        an_d = state_q == DIG0 ? 4'b1110 : state_q == DIG1 ? 4'b1101 :
               state_q == DIG2 ? 4'b1011 : 4'b0111;
`ifdef SUM4_DISP_HEX_EN
        value_d = bus.load_i ? v : value_q;
        dig = state_q == DIG0 ? units_q : state_q == DIG1 ? {2'b00, tens_q} :
              state_q == DIG2 ? value_q[3:0] : {3'b000, value_q[4]};
        blank = !valid_q || (state_q == DIG1 && tens_q == 2'd0 && BLANK_LZ);
`else
        dig = state_q == DIG1 ? {2'b00, tens_q} : units_q;
        blank = !valid_q || state_q == DIG2 || state_q == DIG3 ||
                (state_q == DIG1 && tens_q == 2'd0 && BLANK_LZ);
`endif
        seg_d = blank ? 7'h7F : glyph(dig);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DIG0;
            presc_q <= '0;
            tens_q <= '0;
            units_q <= '0;
            valid_q <= 1'b0;
            seg_q <= 7'h7F;
            an_q <= 4'hF;
`ifdef SUM4_DISP_HEX_EN
            value_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tens_q <= tens_d;
            units_q <= units_d;
            valid_q <= valid_d;
            seg_q <= seg_d;
            an_q <= an_d;
`ifdef SUM4_DISP_HEX_EN
            value_q <= value_d;
`endif
        end
    end

    assign bus.seg_o = seg_q;
    assign bus.an_o = an_q;
    assign bus.disp_valid_o = valid_q;
endmodule
